// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - RV32I fetch-stage program counter with trap/redirect/stall/halt priority
module pc_gen #(
  parameter int unsigned           XLEN         = 32,
  parameter logic [XLEN-1:0]       RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0]       TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned           INC          = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            fetch_valid,
  output logic            misaligned_trap,
  output logic [XLEN-1:0] trap_epc
);

  // Vectors are always word aligned regardless of the parameter value given.
  localparam logic [XLEN-1:0] RESET_PC = {RESET_VECTOR[XLEN-1:2], 2'b00};
  localparam logic [XLEN-1:0] TRAP_PC  = {TRAP_VECTOR[XLEN-1:2], 2'b00};

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            mis_q, mis_d;
  logic            target_misaligned;

  assign target_misaligned = (redirect_target[1:0] != 2'b00);
  assign pc_plus_inc       = pc_q + XLEN'(INC);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    mis_d   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, HALT: begin
        if (trap_valid) begin
          state_d = RUN;
          pc_d    = TRAP_PC;
          epc_d   = pc_q;
        end else if (redirect_valid && target_misaligned) begin
          state_d = RUN;
          pc_d    = TRAP_PC;
          epc_d   = redirect_target;
          mis_d   = 1'b1;
        end else if (redirect_valid) begin
          state_d = RUN;
          pc_d    = redirect_target;
        end else if (state_q == RUN) begin
          if (halt_req) begin
            state_d = HALT;
          end else if (!stall && fetch_ready) begin
            pc_d = pc_plus_inc;
          end
        end else if (!halt_req) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      mis_q   <= mis_d;
    end
  end

  assign pc              = pc_q;
  assign fetch_valid     = (state_q == RUN);
  assign misaligned_trap = mis_q;
  assign trap_epc        = epc_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen (32-bit and 16-bit wrap instances)
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset16;
  logic        stall;
  logic        halt_req;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic        fetch_ready;

  logic [31:0] pc, pc_plus_inc, trap_epc;
  logic        fetch_valid, misaligned_trap;
  logic [15:0] pc16, pc_plus_inc16, trap_epc16;
  logic        fetch_valid16, misaligned_trap16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .halt_req        (halt_req),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .fetch_ready     (fetch_ready),
    .pc              (pc),
    .pc_plus_inc     (pc_plus_inc),
    .fetch_valid     (fetch_valid),
    .misaligned_trap (misaligned_trap),
    .trap_epc        (trap_epc)
  );

  pc_gen #(
    .XLEN         (16),
    .RESET_VECTOR (16'hFFF8),
    .TRAP_VECTOR  (16'h0100),
    .INC          (4)
  ) dut16 (
    .clk             (clk),
    .reset           (reset16),
    .stall           (stall),
    .halt_req        (halt_req),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target[15:0]),
    .trap_valid      (trap_valid),
    .fetch_ready     (fetch_ready),
    .pc              (pc16),
    .pc_plus_inc     (pc_plus_inc16),
    .fetch_valid     (fetch_valid16),
    .misaligned_trap (misaligned_trap16),
    .trap_epc        (trap_epc16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; reset16 = 1'b0;
    stall = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; trap_valid = 1'b0; fetch_ready = 1'b1;

    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'h0);
    chk("rst_mis", 32'(misaligned_trap), 32'h0);
    chk("rst_epc", trap_epc, 32'h0);

    reset = 1'b1;
    #1;
    chk("boot_fv", 32'(fetch_valid), 32'h0);
    step();
    chk("run_fv", 32'(fetch_valid), 32'h1);
    chk("run_pc0", pc, 32'h0);
    step(); chk("seq_pc4", pc, 32'h4);
    step(); chk("seq_pc8", pc, 32'h8);

    stall = 1'b1;
    step(); chk("stall1_pc", pc, 32'h8);
    step(); chk("stall2_pc", pc, 32'h8);
    stall = 1'b0; fetch_ready = 1'b0;
    step(); chk("bp_pc", pc, 32'h8);
    chk("bp_fv", 32'(fetch_valid), 32'h1);
    fetch_ready = 1'b1;
    step(); chk("seq_pcC", pc, 32'hC);
    chk("pc_plus_inc", pc_plus_inc, 32'h10);

    redirect_valid = 1'b1; redirect_target = 32'h40; stall = 1'b1;
    step(); chk("redir_pc", pc, 32'h40);
    chk("redir_mis", 32'(misaligned_trap), 32'h0);
    stall = 1'b0; redirect_target = 32'h42;
    step(); chk("mis_pc", pc, 32'h100);
    chk("mis_epc", trap_epc, 32'h42);
    chk("mis_pulse", 32'(misaligned_trap), 32'h1);
    redirect_valid = 1'b0;
    step(); chk("mis_pulse_end", 32'(misaligned_trap), 32'h0);
    chk("post_mis_pc", pc, 32'h104);

    redirect_valid = 1'b1; redirect_target = 32'h20;
    step(); chk("to20_pc", pc, 32'h20);
    trap_valid = 1'b1; redirect_target = 32'h80;
    step(); chk("trap_pc", pc, 32'h100);
    chk("trap_epc", trap_epc, 32'h20);
    chk("trap_mis", 32'(misaligned_trap), 32'h0);
    trap_valid = 1'b0;

    redirect_target = 32'h10;
    step(); chk("to10_pc", pc, 32'h10);
    redirect_valid = 1'b0; halt_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_fv", 32'(fetch_valid), 32'h0);
      chk("halt_pc", pc, 32'h10);
    end
    halt_req = 1'b0;
    step(); chk("unhalt_fv", 32'(fetch_valid), 32'h1);
    chk("unhalt_pc", pc, 32'h10);
    step(); chk("unhalt_pc14", pc, 32'h14);

    halt_req = 1'b1;
    step(); chk("halt2_fv", 32'(fetch_valid), 32'h0);
    redirect_valid = 1'b1; redirect_target = 32'h60;
    step(); chk("halt_redir_fv", 32'(fetch_valid), 32'h1);
    chk("halt_redir_pc", pc, 32'h60);
    redirect_valid = 1'b0; halt_req = 1'b0;
    step(); chk("post_halt_pc", pc, 32'h64);

    fetch_ready = 1'b0; trap_valid = 1'b1;
    step(); chk("trap_nordy_pc", pc, 32'h100);
    chk("trap_nordy_epc", trap_epc, 32'h64);
    trap_valid = 1'b0; fetch_ready = 1'b1;

    redirect_valid = 1'b1; redirect_target = 32'h43;
    step(); chk("mis2_pulse", 32'(misaligned_trap), 32'h1);
    redirect_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_mis", 32'(misaligned_trap), 32'h0);
    chk("async_epc", trap_epc, 32'h0);
    chk("async_fv", 32'(fetch_valid), 32'h0);

    chk("w_rst_pc", 32'(pc16), 32'h0000_FFF8);
    reset16 = 1'b1;
    step(); chk("w_fv", 32'(fetch_valid16), 32'h1);
    chk("w_pc0", 32'(pc16), 32'h0000_FFF8);
    step(); chk("w_pc1", 32'(pc16), 32'h0000_FFFC);
    step(); chk("w_pc2", 32'(pc16), 32'h0000_0000);
    halt_req = 1'b1;
    step(); chk("w_halt_fv", 32'(fetch_valid16), 32'h0);
    reset16 = 1'b0;
    #1;
    chk("w_async_pc", 32'(pc16), 32'h0000_FFF8);
    chk("w_async_fv", 32'(fetch_valid16), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
